// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets N_REQ producers share one
// FIFO write port. A grant lasts up to MAX_BURST words, ends early on a
// packet's last word or when the granted producer drops valid, and is held
// (not timed out) while the FIFO reports full. Per-producer saturating word
// counters are kept for debug readout.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8,
    localparam int GID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]       req_last_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_wr_en_o,
    output logic [WIDTH-1:0]       fifo_din_o,
    output logic                   grant_active_o,
    output logic [GID_W-1:0]       grant_id_o,
    input  logic                   stat_clr_i,
    input  logic [GID_W-1:0]       cnt_sel_i,
    output logic [CNT_W-1:0]       cnt_val_o
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           state_q;
    logic [GID_W-1:0] grant_id_q;
    logic [GID_W-1:0] rr_last_q;
    logic [BC_W-1:0]  burst_cnt_q;
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    logic             sel_valid;
    logic             sel_last;
    logic [GID_W-1:0] winner_d;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // First requester found scanning upward from last+1, wrapping at N_REQ.
    // The loop runs from the farthest candidate to the nearest so the
    // nearest valid one is the value left standing.
    function automatic logic [GID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [GID_W-1:0] last);
        logic [GID_W-1:0] idx;
        rr_pick = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = GID_W'((int'(last) + k) % N_REQ);
            if (valid[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign winner_d       = rr_pick(req_valid_i, rr_last_q);
    assign grant_active_o = (state_q == S_BURST);
    assign grant_id_o     = grant_id_q;

    // Write-port steering for the granted producer; full gates the write
    // combinationally so a registered full from the FIFO is never overrun.
    always_comb begin
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_din_o   = '0;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        if (state_q == S_BURST) begin
            sel_valid                = req_valid_i[grant_id_q];
            sel_last                 = req_last_i[grant_id_q];
            req_ready_o[grant_id_q]  = ~fifo_full_i;
            fifo_wr_en_o             = sel_valid & ~fifo_full_i;
            fifo_din_o               = req_data_i[grant_id_q*WIDTH +: WIDTH];
        end
    end

    // Grant FSM: arbitrate in IDLE, stream words in BURST until last word,
    // burst limit or the producer going idle; a full FIFO just holds the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_id_q  <= '0;
            rr_last_q   <= GID_W'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        state_q     <= S_BURST;
                        grant_id_q  <= winner_d;
                        burst_cnt_q <= '0;
                    end
                end
                S_BURST: begin
                    if (fifo_wr_en_o) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        if (sel_last || (burst_cnt_q == BC_W'(MAX_BURST - 1))) begin
                            state_q   <= S_IDLE;
                            rr_last_q <= grant_id_q;
                        end
                    end else if (!sel_valid) begin
                        state_q   <= S_IDLE;
                        rr_last_q <= grant_id_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Next counter values: clear beats a same-cycle increment.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr_i) begin
                cnt_d[i] = '0;
            end else if (fifo_wr_en_o && (grant_id_q == GID_W'(i))) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end
        end
    end

    // Per-producer accepted-word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Debug readout; selects beyond the last producer read as zero.
    always_comb begin
        cnt_val_o = '0;
        if (int'(cnt_sel_i) < N_REQ) begin
            cnt_val_o = cnt_q[cnt_sel_i];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (N_REQ=4, WIDTH=4, MAX_BURST=4, CNT_W=8).
// Producers are modelled as word queues; every expected FIFO write is pushed
// by the stimulus and popped by an independent monitor.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [3:0]  fifo_din;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        stat_clr;
    logic [1:0]  cnt_sel;
    logic [7:0]  cnt_val;

    fifo_wr_arbiter #(
        .N_REQ(4), .WIDTH(4), .MAX_BURST(4), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_last_i(req_last),
        .req_ready_o(req_ready),
        .fifo_full_i(fifo_full),
        .fifo_wr_en_o(fifo_wr_en),
        .fifo_din_o(fifo_din),
        .grant_active_o(grant_active),
        .grant_id_o(grant_id),
        .stat_clr_i(stat_clr),
        .cnt_sel_i(cnt_sel),
        .cnt_val_o(cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int wr_count = 0;

    logic [4:0] pmem [4][1024];
    int         head [4];
    int         tail [4];
    logic [5:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int p, input logic [3:0] d, input logic l);
        pmem[p][tail[p]] = {l, d};
        tail[p]++;
    endtask

    task automatic expect_wr(input int p, input logic [3:0] d);
        exp_q.push_back({2'(p), d});
    endtask

    // Producer model: handshake sampled mid-cycle, queues advanced after the edge.
    initial begin
        logic [3:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (fire[i]) head[i]++;
                if (head[i] != tail[i]) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*4 +: 4]   = pmem[i][head[i]][3:0];
                    req_last[i]          = pmem[i][head[i]][4];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*4 +: 4]   = 4'h0;
                    req_last[i]          = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every FIFO write must match the next expected word.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (fifo_wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got id=%0d din=%0h, expected no write (t=%0t)",
                             grant_id, fifo_din, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_word", {26'd0, grant_id, fifo_din}, {26'd0, e});
                end
                chk("wr_ready_onehot", {28'd0, req_ready}, 32'd1 << grant_id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        fifo_full = 1'b0;
        stat_clr = 1'b0;
        cnt_sel = 2'd0;
        @(negedge clk); #1;
        chk("rst_grant_active", grant_active, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_cnt_val", cnt_val, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_wr(input int id, input int budget);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk); #1;
            n++;
            hit = fifo_wr_en && (id < 0 || int'(grant_id) == id);
        end
        chk("wait_wr_timeout", hit, 1);
    endtask

    task automatic drain(input int budget);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk); #1;
            n++;
            done = (exp_q.size() == 0) && !grant_active;
            for (int i = 0; i < 4; i++) if (head[i] != tail[i]) done = 1'b0;
        end
        chk("drain_timeout", done, 1);
    endtask

    initial begin
        int wbase;
        int n;
        rst = 1'b1;
        fifo_full = 1'b0;
        stat_clr = 1'b0;
        cnt_sel = 2'd0;

        // Single producer, 3-word packet.
        do_reset();
        load(0, 4'h1, 0); load(0, 4'h2, 0); load(0, 4'h3, 1);
        expect_wr(0, 4'h1); expect_wr(0, 4'h2); expect_wr(0, 4'h3);
        @(negedge clk); #1;
        chk("sp_idle_first", grant_active, 0);
        chk("sp_no_wr_first", fifo_wr_en, 0);
        @(negedge clk); #1;
        chk("sp_grant_active", grant_active, 1);
        chk("sp_grant_id", grant_id, 0);
        chk("sp_wr1", fifo_wr_en, 1);
        @(negedge clk); #1;
        chk("sp_wr2", fifo_wr_en, 1);
        @(negedge clk); #1;
        chk("sp_wr3", fifo_wr_en, 1);
        @(negedge clk); #1;
        chk("sp_back_idle", grant_active, 0);
        chk("sp_cnt0", cnt_val, 3);

        // Round-robin with all producers always valid, no last.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) load(i, 4'(i*4 + k), 0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) expect_wr(i, 4'(i*4 + r*4 + k));
        wait_wr(0, 10);
        wbase = wr_count - 1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk); #1;
            if (t % 5 == 4) chk("rr_gap", grant_active, 0);
            else chk("rr_gid", grant_id, (t / 5) % 4);
            if (t == 19) chk("rr_rate", wr_count - wbase, 16);
        end
        drain(100);

        // Full backpressure mid-burst.
        do_reset();
        load(0, 4'h5, 0); load(0, 4'h6, 0); load(0, 4'h7, 0); load(0, 4'h8, 0);
        expect_wr(0, 4'h5); expect_wr(0, 4'h6); expect_wr(0, 4'h7); expect_wr(0, 4'h8);
        wait_wr(0, 10);
        @(negedge clk); #1;
        chk("bp_wr2", fifo_wr_en, 1);
        @(posedge clk); #1;
        fifo_full = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            chk("bp_wr_en", fifo_wr_en, 0);
            chk("bp_ready", req_ready, 0);
            chk("bp_hold", {grant_active, grant_id}, 3'b100);
            chk("bp_burst_cnt", dut.burst_cnt_q, 2);
            @(posedge clk); #1;
            if (j == 4) fifo_full = 1'b0;
        end
        @(negedge clk); #1;
        chk("bp_resume3", fifo_wr_en, 1);
        @(negedge clk); #1;
        chk("bp_resume4", fifo_wr_en, 1);
        @(negedge clk); #1;
        chk("bp_end", grant_active, 0);
        drain(20);

        // Valid drop: p2 released after one word, next grant p3, then wrap to p0.
        do_reset();
        load(1, 4'h9, 1); expect_wr(1, 4'h9);
        drain(20);
        load(2, 4'hA, 0); load(3, 4'hB, 1); load(0, 4'hC, 1);
        expect_wr(2, 4'hA); expect_wr(3, 4'hB); expect_wr(0, 4'hC);
        wait_wr(2, 10);
        @(negedge clk); #1;
        chk("vd_release_cycle", {grant_active, fifo_wr_en}, 2'b10);
        @(negedge clk); #1;
        chk("vd_idle", grant_active, 0);
        @(negedge clk); #1;
        chk("vd_next_p3", {grant_active, grant_id}, 3'b111);
        drain(30);
        load(2, 4'hD, 0); load(0, 4'hE, 1);
        expect_wr(2, 4'hD); expect_wr(0, 4'hE);
        drain(30);

        // Reset during producer 1's burst.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) load(i, 4'(k + 8), 0);
        for (int k = 0; k < 4; k++) expect_wr(0, 4'(k + 8));
        expect_wr(1, 4'h8); expect_wr(1, 4'h9);
        wait_wr(1, 20);
        @(negedge clk); #1;
        chk("mr_p1_wr2", fifo_wr_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("mr_async_ga", grant_active, 0);
        chk("mr_async_wr", fifo_wr_en, 0);
        chk("mr_async_ready", req_ready, 0);
        chk("mr_async_din", fifo_din, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) tail[i] = head[i];
        @(negedge clk); #1;
        chk("mr_held_wr", fifo_wr_en, 0);
        chk("mr_held_exp", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            load(i, 4'(i + 1), 0); load(i, 4'(i + 5), 1);
        end
        for (int i = 0; i < 4; i++) begin
            expect_wr(i, 4'(i + 1)); expect_wr(i, 4'(i + 5));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (!grant_active && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mr_first_grant", {grant_active, grant_id}, 3'b100);
        drain(60);

        // Counter saturation and clear-vs-increment.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            load(1, 4'(k), 0);
            expect_wr(1, 4'(k));
        end
        drain(1000);
        cnt_sel = 2'd1; #1;
        chk("cnt_sat_p1", cnt_val, 255);
        cnt_sel = 2'd0; #1;
        chk("cnt_p0_zero", cnt_val, 0);
        load(0, 4'h1, 0); load(0, 4'h2, 0);
        expect_wr(0, 4'h1); expect_wr(0, 4'h2);
        wait_wr(0, 10);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        chk("clr_wins_p0", cnt_val, 0);
        cnt_sel = 2'd1; #1;
        chk("clr_p1", cnt_val, 0);
        drain(20);
        cnt_sel = 2'd0; #1;
        chk("cnt_after_clr", cnt_val, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
